mem_arbiter: RTL and testbench

- Memory-side responder for the cache/control (ccif) protocol. It serves the icache (read-only) and the dcache (read/write) from a single shared RAM port.
- Arbitrates between the two caches, forwards the granted request to RAM, and drives the per-cache wait/load responses.
- Handles RAM errors and hung accesses through a timeout, so a cache never stalls forever.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/mem_timeout_counter.sv | 30 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory control path.
// RAM handshake states, arbiter states and grant tags.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    D_ACC,
    I_ACC
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Per-access cycle counter; expire flags the last allowed
// RAM cycle and the count saturates there.
module mem_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] MAXC = W'(TIMEOUT - 1);

  logic [W-1:0] tmoCnt;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      tmoCnt <= '0;
    end else if (clear) begin
      tmoCnt <= '0;
    end else if (enable && tmoCnt != MAXC) begin
      tmoCnt <= tmoCnt + 1'b1;
    end
  end

  assign expire = (tmoCnt == MAXC);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between icache and dcache with
// strict alternation under contention and an access timeout.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int    TIMEOUT  = 64,
  parameter word_t ERR_WORD = 32'hBAD1BAD1
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      bus_err
);

  arb_state_t state, nxtState;
  grant_t     lastGrant, nxtGrant;
  logic       setErr;
  logic       expire;
  logic       dreq;
  logic       gD;
  logic       req, rd, wr, done;
  word_t      data;

  assign dreq = dREN | dWEN;
  assign gD   = (state == D_ACC);

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) uTmo (
    .CLK    (CLK),
    .nRST   (nRST),
    .clear  (state == IDLE),
    .enable ((state != IDLE) &&
             (ramstate == FREE || ramstate == BUSY)),
    .expire (expire)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      lastGrant <= GRANT_I;
      bus_err   <= 1'b0;
    end else begin
      state     <= nxtState;
      lastGrant <= nxtGrant;
      if (setErr) bus_err <= 1'b1;
    end
  end

  always_comb begin
    nxtState = state;
    nxtGrant = lastGrant;
    setErr   = 1'b0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    req      = 1'b0;
    rd       = 1'b0;
    wr       = 1'b0;
    done     = 1'b0;
    data     = '0;
    unique case (state)
      IDLE: begin
        if (dreq && (!iREN || lastGrant == GRANT_I))
          nxtState = D_ACC;
        else if (iREN)
          nxtState = I_ACC;
      end
      D_ACC, I_ACC: begin
        req      = gD ? dreq : iREN;
        rd       = gD ? (dREN & ~dWEN) : iREN;
        wr       = gD & dWEN;
        ramaddr  = gD ? daddr : iaddr;
        ramstore = gD ? dstore : '0;
        if (!req) begin
          nxtState = IDLE;
        end else if (ramstate == ACCESS) begin
          ramREN = rd;
          ramWEN = wr;
          done   = 1'b1;
          data   = wr ? '0 : ramload;
        end else if (ramstate == ERROR || expire) begin
          // aborted: enables drop so RAM sees no half access
          done   = 1'b1;
          data   = ERR_WORD;
          setErr = 1'b1;
        end else begin
          ramREN = rd;
          ramWEN = wr;
        end
        if (done) begin
          nxtState = IDLE;
          nxtGrant = gD ? GRANT_D : GRANT_I;
          if (gD) begin
            dwait = 1'b0;
            dload = data;
          end else begin
            iwait = 1'b0;
            iload = data;
          end
        end
      end
      default: nxtState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed checks of mem_arbiter against
// a transaction-level owner/age reference model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TMO = 8;
  localparam logic [31:0] ERRW = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] iaddr = '0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic [31:0] ramload = '0;
  ramstate_t   ramstate = FREE;
  logic        iwait, dwait, ramREN, ramWEN, bus_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  // model: owner 0=none 1=D 2=I, age = RAM cycles spent
  int owner = 0;
  int age = 0;
  bit lastD = 1'b0;
  bit errF = 1'b0;
  bit obsD, obsI;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .TIMEOUT  (TMO),
    .ERR_WORD (ERRW)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .bus_err  (bus_err)
  );

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // one clock: inputs already set at negedge
  task automatic cycle();
    logic [31:0] eIl, eDl, eA, eS, val;
    bit eIw, eDw, eR, eW;
    bit isD, req, rd, wr, fin;
    int nOwn, nAge;
    bit nLast, nErr;
    #1;
    eIw = 1; eDw = 1; eIl = 0; eDl = 0;
    eR = 0; eW = 0; eA = 0; eS = 0; val = 0;
    nOwn = owner; nAge = age; nLast = lastD; nErr = errF;
    if (owner == 0) begin
      nAge = 0;
      if ((dREN || dWEN) && iREN) nOwn = lastD ? 2 : 1;
      else if (dREN || dWEN) nOwn = 1;
      else if (iREN) nOwn = 2;
    end else begin
      isD = (owner == 1);
      req = isD ? (dREN || dWEN) : iREN;
      rd  = isD ? (dREN && !dWEN) : iREN;
      wr  = isD && dWEN;
      eA  = isD ? daddr : iaddr;
      eS  = isD ? dstore : 32'h0;
      fin = 0;
      if (!req) begin
        nOwn = 0;
      end else if (ramstate == ACCESS) begin
        eR = rd; eW = wr; fin = 1;
        val = wr ? 32'h0 : ramload;
      end else if (ramstate == ERROR || age >= TMO - 1) begin
        fin = 1; val = ERRW; nErr = 1;
      end else begin
        eR = rd; eW = wr; nAge = age + 1;
      end
      if (fin) begin
        nOwn = 0;
        nLast = isD;
        if (isD) begin eDw = 0; eDl = val; end
        else begin eIw = 0; eIl = val; end
      end
    end
    chk("iwait", 32'(iwait), 32'(eIw));
    chk("dwait", 32'(dwait), 32'(eDw));
    chk("iload", iload, eIl);
    chk("dload", dload, eDl);
    chk("ramREN", 32'(ramREN), 32'(eR));
    chk("ramWEN", 32'(ramWEN), 32'(eW));
    chk("ramaddr", ramaddr, eA);
    chk("ramstore", ramstore, eS);
    chk("bus_err", 32'(bus_err), 32'(errF));
    obsD = !dwait;
    obsI = !iwait;
    @(posedge CLK);
    if (!nRST) begin
      owner = 0; age = 0; lastD = 0; errF = 0;
    end else begin
      owner = nOwn; age = nAge; lastD = nLast; errF = nErr;
    end
    @(negedge CLK);
  endtask

  // FREE in the grant cycle, then busy BUSY cycles, then fin
  task automatic xfer(input bit isD, input bit wr,
                      input int busy, input ramstate_t fin,
                      output int lat);
    lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      if (isD) begin dREN = !wr; dWEN = wr; end
      else iREN = 1;
      ramstate = (k == 0) ? FREE : ((k <= busy) ? BUSY : fin);
      ramload = $urandom;
      cycle();
      if (isD ? obsD : obsI) lat = k;
    end
    dREN = 0; dWEN = 0; iREN = 0;
  endtask

  initial begin
    int lat;
    logic [7:0] dv, iv;
    bit dPend, dW, iPend;
    int r;
    nRST = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_iload", iload, 32'h0);
    chk("rst_dload", dload, 32'h0);
    chk("rst_ren", 32'(ramREN), 32'd0);
    chk("rst_wen", 32'(ramWEN), 32'd0);
    chk("rst_addr", ramaddr, 32'h0);
    chk("rst_store", ramstore, 32'h0);
    chk("rst_err", 32'(bus_err), 32'd0);
    nRST = 1;

    // contention from reset: D, I, D, I
    iREN = 1; dREN = 1; iaddr = 32'h40; daddr = 32'h80;
    ramstate = ACCESS;
    dv = 0; iv = 0;
    for (int k = 0; k < 8; k++) begin
      ramload = $urandom;
      cycle();
      dv[k] = obsD;
      iv[k] = obsI;
    end
    iREN = 0; dREN = 0;
    chk("alt_d", 32'(dv), 32'h22);
    chk("alt_i", 32'(iv), 32'h88);
    ramstate = FREE;
    cycle();

    daddr = 32'h100;
    xfer(1'b1, 1'b0, 3, ACCESS, lat);
    chk("rd_lat", 32'(lat), 32'd4);

    daddr = 32'h3100; dstore = 32'h12;
    xfer(1'b1, 1'b1, 1, ACCESS, lat);
    chk("wr_lat", 32'(lat), 32'd2);

    iaddr = 32'h200;
    xfer(1'b0, 1'b0, 0, ERROR, lat);
    chk("ierr_lat", 32'(lat), 32'd1);
    chk("ierr_sticky", 32'(bus_err), 32'd1);

    daddr = 32'h500;
    xfer(1'b1, 1'b0, 1000, BUSY, lat);
    chk("tmo_lat", 32'(lat), 32'd8);
    chk("tmo_sticky", 32'(bus_err), 32'd1);

    // reset in the middle of a D access
    dREN = 1; daddr = 32'h700;
    ramstate = FREE;
    cycle();
    ramstate = BUSY;
    cycle();
    nRST = 0;
    cycle();
    nRST = 1;
    chk("rst_mid_err", 32'(bus_err), 32'd0);
    xfer(1'b1, 1'b0, 2, ACCESS, lat);
    chk("rst_regrant", 32'(lat), 32'd3);

    dPend = 0; dW = 0; iPend = 0;
    for (int n = 0; n < 3000; n++) begin
      if (obsD) dPend = 0;
      if (obsI) iPend = 0;
      if (dPend && $urandom_range(49) == 0) dPend = 0;
      if (iPend && $urandom_range(49) == 0) iPend = 0;
      if (!dPend && $urandom_range(2) == 0) begin
        dPend = 1;
        dW = 1'($urandom_range(1));
        daddr = $urandom;
        dstore = $urandom;
      end
      if (!iPend && $urandom_range(2) == 0) begin
        iPend = 1;
        iaddr = $urandom;
      end
      dREN = dPend && !dW;
      dWEN = dPend && dW;
      iREN = iPend;
      r = $urandom_range(99);
      ramstate = (r < 35) ? FREE : (r < 65) ? BUSY :
                 (r < 97) ? ACCESS : ERROR;
      ramload = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
